// File: rtl/fifo_wrapper_with_delay.sv
// FIFO whose words become visible at the head only after a minimum residence of DELAY cycles.
// Each entry carries a write timestamp plus a sticky "aged" flag, so a long stay in the queue never re-blocks it.
module fifo_wrapper_with_delay #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 128,
  parameter int DELAY = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] input_data,
  input  logic             input_valid,
  output logic             input_ready,
  output logic [WIDTH-1:0] output_data,
  output logic             output_valid,
  input  logic             output_ready
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DELAY) + 2;
  localparam logic [CW-1:0] DLY = CW'(DELAY);

  logic [WIDTH-1:0] mem_data [DEPTH];
  logic [CW-1:0]    mem_ts   [DEPTH];
  logic [DEPTH-1:0] aged;
  logic [DEPTH-1:0] elig;

  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;
  logic [CW-1:0]    cycle_cnt;
  logic             valid_q;
  logic [WIDTH-1:0] data_q;

  logic             write;
  logic             read;
  logic [AW-1:0]    head_idx;
  logic [AW:0]      remain;
  logic             next_valid;

  assign input_ready  = (count < (AW+1)'(DEPTH)) && !reset;
  assign output_valid = valid_q;
  assign output_data  = data_q;

  assign write = input_valid && input_ready;
  assign read  = valid_q && output_ready;

  // Modular age compare stays correct as long as the word is examined
  // before its age wraps; the sticky flag covers longer residence.
  always_comb begin
    elig = '0;
    for (int i = 0; i < DEPTH; i++) begin
      elig[i] = aged[i] | ((cycle_cnt - mem_ts[i]) >= DLY);
    end
  end

  // Head after this edge: a word written at this edge has age 0 and is never eligible.
  assign head_idx   = rd_ptr + AW'(read);
  assign remain     = count - (AW+1)'(read);
  assign next_valid = (remain != '0) && elig[head_idx];

  always_ff @(posedge clk) begin
    if (write) begin
      mem_data[wr_ptr] <= input_data;
      mem_ts[wr_ptr]   <= cycle_cnt;
    end
    for (int i = 0; i < DEPTH; i++) begin
      aged[i] <= (write && wr_ptr == AW'(i)) ? 1'b0 : elig[i];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      cycle_cnt <= '0;
      valid_q   <= 1'b0;
      data_q    <= '0;
    end else begin
      cycle_cnt <= cycle_cnt + CW'(1);
      if (write) wr_ptr <= wr_ptr + AW'(1);
      if (read)  rd_ptr <= rd_ptr + AW'(1);
      if (write && !read)      count <= count + (AW+1)'(1);
      else if (!write && read) count <= count - (AW+1)'(1);
      valid_q <= next_valid;
      if (next_valid) data_q <= mem_data[head_idx];
    end
  end

endmodule

// File: tb/tb_fifo_wrapper_with_delay.sv
// Bench for fifo_wrapper_with_delay: directed scenarios plus random traffic, every cycle
// compared against a queue model that tracks absolute write cycles.
module tb_fifo_wrapper_with_delay;
  localparam int WIDTH = 64;
  localparam int DEPTH = 4;
  localparam int DELAY = 3;

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic [WIDTH-1:0] input_data = '0;
  logic             input_valid = 1'b0;
  logic             input_ready;
  logic [WIDTH-1:0] output_data;
  logic             output_valid;
  logic             output_ready = 1'b0;

  int total  = 0;
  int passed = 0;
  int reads  = 0;
  int r0;

  typedef struct {
    logic [63:0] d;
    int unsigned w;
  } ent_t;

  ent_t        q[$];
  logic        exp_valid = 1'b0;
  logic [63:0] exp_data  = '0;
  int unsigned edge_no   = 0;

  fifo_wrapper_with_delay #(.WIDTH(WIDTH), .DEPTH(DEPTH), .DELAY(DELAY)) dut (
    .clk(clk),
    .reset(reset),
    .input_data(input_data),
    .input_valid(input_valid),
    .input_ready(input_ready),
    .output_data(output_data),
    .output_valid(output_valid),
    .output_ready(output_ready)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%h expected=%h (cycle %0d)", tag, obs, exp, edge_no);
  endtask

  // Called at a falling edge; drives inputs, checks, advances one clock, checks again.
  task automatic step(input logic v, input logic [63:0] d, input logic r, input logic rst);
    logic exp_ready;
    logic wr, rd;
    input_valid  = v;
    input_data   = d;
    output_ready = r;
    reset        = rst;
    #1;
    exp_ready = (q.size() < DEPTH) && !rst;
    chk("input_ready", {63'd0, input_ready}, {63'd0, exp_ready});
    if (output_valid && output_ready) reads++;
    @(posedge clk);
    if (rst) begin
      q.delete();
      exp_valid = 1'b0;
      exp_data  = '0;
    end else begin
      wr = v && exp_ready;
      rd = exp_valid && r;
      if (rd) void'(q.pop_front());
      if (wr) q.push_back('{d, edge_no});
      if (q.size() > 0 && (edge_no - q[0].w) >= DELAY) begin
        exp_valid = 1'b1;
        exp_data  = q[0].d;
      end else begin
        exp_valid = 1'b0;
      end
    end
    edge_no++;
    @(negedge clk);
    chk("output_valid", {63'd0, output_valid}, {63'd0, exp_valid});
    chk("output_data", output_data, exp_data);
  endtask

  initial begin
    @(negedge clk);
    for (int i = 0; i < 3; i++) step(1'b0, '0, 1'b0, 1'b1);
    for (int i = 0; i < 3; i++) step(1'b0, '0, 1'b1, 1'b0);

    // single word, minimum latency
    r0 = reads;
    step(1'b1, 64'hA5, 1'b1, 1'b0);
    for (int i = 0; i < 6; i++) step(1'b0, '0, 1'b1, 1'b0);
    chk("single_reads", 64'(reads - r0), 64'd1);

    // back-to-back stream
    r0 = reads;
    for (int i = 1; i <= 4; i++) step(1'b1, 64'(i), 1'b1, 1'b0);
    for (int i = 0; i < 6; i++) step(1'b0, '0, 1'b1, 1'b0);
    chk("stream_reads", 64'(reads - r0), 64'd4);

    // overflow attempt with consumer stalled
    r0 = reads;
    for (int i = 1; i <= 5; i++) step(1'b1, 64'(16 + i), 1'b0, 1'b0);
    for (int i = 0; i < 8; i++) step(1'b0, '0, 1'b1, 1'b0);
    chk("overflow_reads", 64'(reads - r0), 64'd4);

    // full queue, then simultaneous read and write pressure
    for (int i = 1; i <= 4; i++) step(1'b1, 64'(32 + i), 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) step(1'b0, '0, 1'b0, 1'b0);
    for (int i = 1; i <= 6; i++) step(1'b1, 64'(48 + i), 1'b1, 1'b0);
    for (int i = 0; i < 8; i++) step(1'b0, '0, 1'b1, 1'b0);

    // reset mid-operation discards stored words
    step(1'b1, 64'h71, 1'b0, 1'b0);
    step(1'b1, 64'h72, 1'b0, 1'b0);
    step(1'b0, '0, 1'b0, 1'b1);
    step(1'b0, '0, 1'b0, 1'b1);
    r0 = reads;
    for (int i = 0; i < 8; i++) step(1'b0, '0, 1'b1, 1'b0);
    chk("post_reset_reads", 64'(reads - r0), 64'd0);

    // random traffic well past counter wrap
    for (int i = 0; i < 400; i++)
      step(1'($urandom_range(0, 1)), {$urandom, $urandom}, ($urandom_range(0, 3) != 0), 1'b0);
    for (int i = 0; i < 200; i++)
      step(($urandom_range(0, 2) == 0), {$urandom, $urandom}, 1'b1, 1'b0);
    for (int i = 0; i < 10; i++) step(1'b0, '0, 1'b1, 1'b0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
